// File: rtl/bitstream_loader_if.sv
// Host byte stream, sequencer bit-read port and status flags of bitstream_loader.
interface bitstream_loader_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;
    logic              busy;
    logic              cfg_trigger;
    logic              load_error;

    modport master (
        output start, s_data, s_valid, rd_addr,
        input  s_ready, rd_data, busy, cfg_trigger, load_error
    );

    modport slave (
        input  start, s_data, s_valid, rd_addr,
        output s_ready, rd_data, busy, cfg_trigger, load_error
    );
endinterface

// File: rtl/bitstream_loader.sv
// Loads the eFPGA bitstream byte-wise into a bit-addressable RAM and raises cfg_trigger when complete.
// Optional trailing CRC-8 check is enabled with `define BITSTREAM_LOADER_CRC_EN.
module bitstream_loader #(
    parameter int BITSTREAM_LENGTH = 7286,
    parameter int ADDR_W           = $clog2(BITSTREAM_LENGTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    bitstream_loader_if.slave  bus
);
    localparam int                NBYTES    = (BITSTREAM_LENGTH + 7) / 8;
    localparam int                CNT_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] LEN_A     = ADDR_W'(BITSTREAM_LENGTH);

`ifdef BITSTREAM_LOADER_CRC_EN
    typedef enum logic [2:0] {IDLE, LOAD, CRC, DONE, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    state_t           state, state_nx;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_nx;
    logic [7:0]       mem [NBYTES];
    logic             hs;
    logic             wr_en;
    logic [CNT_W-1:0] rd_byte;

`ifdef BITSTREAM_LOADER_CRC_EN
    logic [7:0] crc, crc_nx;

    // CRC-8 poly 0x07, MSB first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction
`endif

    // A byte offered in the same cycle as start is dropped.
    assign hs    = bus.s_valid && bus.s_ready && !bus.start;
    assign wr_en = hs && (state == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
`ifdef BITSTREAM_LOADER_CRC_EN
            crc      <= '0;
`endif
        end else begin
            state    <= state_nx;
            byte_cnt <= byte_cnt_nx;
`ifdef BITSTREAM_LOADER_CRC_EN
            crc      <= crc_nx;
`endif
        end
    end

    always_comb begin
        state_nx        = state;
        byte_cnt_nx     = byte_cnt;
`ifdef BITSTREAM_LOADER_CRC_EN
        crc_nx          = crc;
`endif
        bus.s_ready     = 1'b0;
        bus.busy        = 1'b0;
        bus.cfg_trigger = 1'b0;
        bus.load_error  = 1'b0;
        case (state)
            IDLE: ;
            LOAD: begin
                bus.s_ready = 1'b1;
                bus.busy    = 1'b1;
                if (hs) begin
                    byte_cnt_nx = byte_cnt + 1'b1;
`ifdef BITSTREAM_LOADER_CRC_EN
                    crc_nx = crc8_step(crc, bus.s_data);
                    if (byte_cnt == LAST_BYTE) state_nx = CRC;
`else
                    if (byte_cnt == LAST_BYTE) state_nx = DONE;
`endif
                end
            end
`ifdef BITSTREAM_LOADER_CRC_EN
            CRC: begin
                bus.s_ready = 1'b1;
                bus.busy    = 1'b1;
                if (hs) state_nx = (bus.s_data == crc) ? DONE : ERROR;
            end
            ERROR: bus.load_error = 1'b1;
`endif
            DONE: bus.cfg_trigger = 1'b1;
            default: state_nx = IDLE;
        endcase
        if (bus.start) begin
            state_nx    = LOAD;
            byte_cnt_nx = '0;
`ifdef BITSTREAM_LOADER_CRC_EN
            crc_nx      = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[byte_cnt] <= bus.s_data;
    end

    // Padding bits of the last byte and the end address read back as 0.
    assign rd_byte     = CNT_W'(bus.rd_addr >> 3);
    assign bus.rd_data = (bus.rd_addr < LEN_A) ? mem[rd_byte][bus.rd_addr[2:0]] : 1'b0;

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed-sequence bench for bitstream_loader with randomized stream data and a byte-array model.
// Also exercises the CRC variant when BITSTREAM_LOADER_CRC_EN is defined.
module tb_bitstream_loader;
    localparam int LEN   = 7286;
    localparam int NB    = (LEN + 7) / 8;
    localparam int AW    = $clog2(LEN) + 1;
    localparam int LEN_S = 12;
    localparam int AW_S  = $clog2(LEN_S) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitstream_loader_if #(.ADDR_W(AW))   bus ();
    bitstream_loader_if #(.ADDR_W(AW_S)) sbus ();

    bitstream_loader #(.BITSTREAM_LENGTH(LEN), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    bitstream_loader #(.BITSTREAM_LENGTH(LEN_S), .ADDR_W(AW_S)) u_small (
        .clk(clk), .rst(rst), .bus(sbus.slave)
    );

`ifdef BITSTREAM_LOADER_CRC_EN
    bitstream_loader_if #(.ADDR_W(4)) cbus ();
    bitstream_loader #(.BITSTREAM_LENGTH(8), .ADDR_W(4)) u_crc (
        .clk(clk), .rst(rst), .bus(cbus.slave)
    );
`endif

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [7:0] model_mem [NB];
    logic [7:0] tx [$];

    always @(negedge clk)
        if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1 && bus.start === 1'b0) hs_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    function automatic logic exp_bit(input int a);
        if (a >= LEN) return 1'b0;
        return model_mem[a / 8][a % 8];
    endfunction

    // New random image; tx gets the data bytes plus the CRC byte when enabled.
    task automatic new_image();
        logic [7:0] c;
        c = 8'h00;
        tx.delete();
        for (int i = 0; i < NB; i++) begin
            model_mem[i] = 8'($urandom);
            c = crc8(c, model_mem[i]);
            tx.push_back(model_mem[i]);
        end
`ifdef BITSTREAM_LOADER_CRC_EN
        tx.push_back(c);
`endif
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Streams tx[0..n-1] with random s_valid gaps; flags an early cfg_trigger and a stuck stream.
    task automatic send_big(input int n, output bit trig_early, output bit timeout);
        int  i;
        int  budget;
        bit  hs;
        i = 0; budget = 0; trig_early = 0; timeout = 0;
        while (i < n) begin
            bus.s_data  = tx[i];
            bus.s_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.cfg_trigger !== 1'b0) trig_early = 1;
            hs = bus.s_valid && (bus.s_ready === 1'b1);
            @(posedge clk); #1;
            if (hs) i++;
            budget++;
            if (budget > 20000) begin
                timeout = 1;
                break;
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a <= LEN; a++) begin
            bus.rd_addr = AW'(a);
            #1;
            chk(tag, 32'(bus.rd_data), 32'(exp_bit(a)));
        end
    endtask

    task automatic idle_push(input string tag);
        int base;
        base = hs_cnt;
        for (int k = 0; k < 10; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom);
            @(negedge clk);
            chk(tag, 32'(bus.s_ready), 0);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        chk({tag, "_hs"}, 32'(hs_cnt - base), 0);
    endtask

    task automatic push_s(input logic [7:0] d);
        sbus.s_data  = d;
        sbus.s_valid = 1'b1;
        @(negedge clk);
        chk("small_ready", 32'(sbus.s_ready), 1);
        @(posedge clk); #1;
        sbus.s_valid = 1'b0;
    endtask

`ifdef BITSTREAM_LOADER_CRC_EN
    task automatic push_c(input logic [7:0] d);
        cbus.s_data  = d;
        cbus.s_valid = 1'b1;
        @(posedge clk); #1;
        cbus.s_valid = 1'b0;
    endtask

    task automatic start_c();
        cbus.start = 1'b1;
        @(posedge clk); #1;
        cbus.start = 1'b0;
    endtask
`endif

    initial begin
        bit                trig_early;
        bit                timeout;
        int                base;
        logic [LEN_S:0]    exp_s;
        logic [7:0]        crc_s;

        bus.start = 0;  bus.s_valid = 0;  bus.s_data = 0;  bus.rd_addr = '0;
        sbus.start = 0; sbus.s_valid = 0; sbus.s_data = 0; sbus.rd_addr = '0;
`ifdef BITSTREAM_LOADER_CRC_EN
        cbus.start = 0; cbus.s_valid = 0; cbus.s_data = 0; cbus.rd_addr = '0;
`endif
        #2;
        chk("rst_ready", 32'(bus.s_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_trig", 32'(bus.cfg_trigger), 0);
        chk("rst_err", 32'(bus.load_error), 0);
        chk("rst_small_ready", 32'(sbus.s_ready), 0);
        chk("rst_small_trig", 32'(sbus.cfg_trigger), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        idle_push("idle_ready");

        // Short image: 0xA5, 0x3C over 12 bits.
        sbus.start = 1'b1;
        @(posedge clk); #1;
        sbus.start = 1'b0;
        chk("small_busy", 32'(sbus.busy), 1);
        push_s(8'hA5);
        chk("small_trig_mid", 32'(sbus.cfg_trigger), 0);
        push_s(8'h3C);
`ifdef BITSTREAM_LOADER_CRC_EN
        crc_s = crc8(crc8(8'h00, 8'hA5), 8'h3C);
        chk("small_trig_pre_crc", 32'(sbus.cfg_trigger), 0);
        push_s(crc_s);
`else
        crc_s = 8'h00;
`endif
        chk("small_trig", 32'(sbus.cfg_trigger), 1);
        chk("small_done_ready", 32'(sbus.s_ready), 0);
        exp_s = 13'b0_1100_1010_0101;
        for (int a = 0; a <= LEN_S; a++) begin
            sbus.rd_addr = AW_S'(a);
            #1;
            chk("small_bit", 32'(sbus.rd_data), 32'(exp_s[a]));
        end

        // Full-length stream with random valid gaps.
        new_image();
        pulse_start();
        chk("start_ready", 32'(bus.s_ready), 1);
        chk("start_busy", 32'(bus.busy), 1);
        base = hs_cnt;
        send_big(tx.size(), trig_early, timeout);
        chk("full_timeout", 32'(timeout), 0);
        chk("full_hs", 32'(hs_cnt - base), 32'(tx.size()));
        chk("full_trig_early", 32'(trig_early), 0);
        chk("full_trig", 32'(bus.cfg_trigger), 1);
        chk("full_ready", 32'(bus.s_ready), 0);
        chk("full_busy", 32'(bus.busy), 0);
        chk("full_err", 32'(bus.load_error), 0);
        sweep("full_bit");

        idle_push("done_ready");
        chk("done_trig_hold", 32'(bus.cfg_trigger), 1);
        sweep("done_bit");

        // Restart after 3 bytes; the second start lands on a handshake whose byte must be dropped.
        pulse_start();
        chk("restart_trig_clr", 32'(bus.cfg_trigger), 0);
        tx.delete();
        for (int i = 0; i < 3; i++) tx.push_back(8'($urandom));
        send_big(3, trig_early, timeout);
        chk("junk_timeout", 32'(timeout), 0);
        new_image();
        bus.s_valid = 1'b1;
        bus.s_data  = ~tx[0];
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        base = hs_cnt;
        send_big(tx.size(), trig_early, timeout);
        chk("restart_timeout", 32'(timeout), 0);
        chk("restart_hs", 32'(hs_cnt - base), 32'(tx.size()));
        chk("restart_trig_early", 32'(trig_early), 0);
        chk("restart_trig", 32'(bus.cfg_trigger), 1);
        sweep("restart_bit");

        // Reset while DONE drops the trigger without waiting for a clock.
        #2 rst = 1'b1;
        #1 chk("rst_done_trig", 32'(bus.cfg_trigger), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset mid-load.
        new_image();
        pulse_start();
        send_big(5, trig_early, timeout);
        chk("midload_busy", 32'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midload_rst_ready", 32'(bus.s_ready), 0);
        chk("midload_rst_busy", 32'(bus.busy), 0);
        chk("midload_rst_trig", 32'(bus.cfg_trigger), 0);
        chk("midload_rst_err", 32'(bus.load_error), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bus.s_ready), 0);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_trig", 32'(bus.cfg_trigger), 0);

`ifdef BITSTREAM_LOADER_CRC_EN
        start_c();
        push_c(8'h01);
        chk("crc_busy", 32'(cbus.busy), 1);
        push_c(crc8(8'h00, 8'h01));
        chk("crc_ok_trig", 32'(cbus.cfg_trigger), 1);
        chk("crc_ok_err", 32'(cbus.load_error), 0);
        start_c();
        push_c(8'h01);
        push_c(8'h06);
        chk("crc_bad_err", 32'(cbus.load_error), 1);
        chk("crc_bad_trig", 32'(cbus.cfg_trigger), 0);
        chk("crc_bad_ready", 32'(cbus.s_ready), 0);
        start_c();
        chk("crc_clr_err", 32'(cbus.load_error), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
